// File: rtl/direction_input_pkg.sv
// Shared direction bit indices and repeat-FSM encoding for the cursor key path.
// Also holds the opposing-key cancel so the movement logic can reuse it.
package direction_input_pkg;

   localparam int DIR_LEFT  = 3;
   localparam int DIR_UP    = 2;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_DOWN  = 0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      DELAY  = ST_DELAY,
      REPEAT = ST_REPEAT
   } state_t;

   // Opposing pairs pressed together cancel so neither axis moves.
   function automatic logic [3:0] cancel_opposing(input logic [3:0] k);
      logic [3:0] e;
      e = k;
      if (k[DIR_LEFT] && k[DIR_RIGHT]) begin
         e[DIR_LEFT]  = 1'b0;
         e[DIR_RIGHT] = 1'b0;
      end
      if (k[DIR_UP] && k[DIR_DOWN]) begin
         e[DIR_UP]   = 1'b0;
         e[DIR_DOWN] = 1'b0;
      end
      return e;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debounce for one active-low key.
// Latency: held follows a clean edge DEBOUNCE_CYCLES+2 cycles later; no backpressure.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 24
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic held
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             synced;
   logic [CNT_W-1:0] cnt;

   assign synced = ~sync2;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         cnt   <= '0;
         held  <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         if (synced == held) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            held <= ~held;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/direction_input.sv
// Turns four raw push-buttons into one-cycle cursor step pulses with typematic repeat.
// Latency: first step DEBOUNCE_CYCLES+3 after press; no backpressure, pulses are fire-and-forget.
module direction_input
   import direction_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int INITIAL_DELAY   = 15000000,
   parameter int REPEAT_PERIOD   = 2500000,
   parameter int CNT_W           = 24
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:0] keys_n,
   output logic [3:0] directions,
   output logic [3:0] held
);

   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(INITIAL_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [3:0]       eff;
   logic [3:0]       eff_prev;
   logic [3:0]       rise;
   logic [CNT_W-1:0] timer;
   state_t           state;

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .clock  (clock),
         .resetn (resetn),
         .key_n  (keys_n[i]),
         .held   (held[i])
      );
   end

   assign eff  = cancel_opposing(held);
   assign rise = eff & ~eff_prev;

   // A newly added direction restarts the initial delay so it steps immediately.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         timer      <= '0;
         directions <= '0;
         eff_prev   <= '0;
      end else begin
         eff_prev   <= eff;
         directions <= '0;
         case (state)
            IDLE: begin
               if (eff != '0) begin
                  directions <= eff;
                  timer      <= '0;
                  state      <= DELAY;
               end
            end
            DELAY: begin
               if (eff == '0) begin
                  state <= IDLE;
               end else if (rise != '0) begin
                  directions <= eff;
                  timer      <= '0;
               end else if (timer == DLY_LAST) begin
                  directions <= eff;
                  timer      <= '0;
                  state      <= REPEAT;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (eff == '0) begin
                  state <= IDLE;
               end else if (rise != '0) begin
                  directions <= eff;
                  timer      <= '0;
                  state      <= DELAY;
               end else if (timer == REP_LAST) begin
                  directions <= eff;
                  timer      <= '0;
               end else begin
                  timer <= timer + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with short debounce/delay parameters.
// Cycle c means "sampled 1 ns after the c-th rising edge following the stimulus change".
module tb_direction_input;

   logic       clock;
   logic       resetn;
   logic [3:0] keys_n;
   logic [3:0] directions;
   logic [3:0] held;

   int checks = 0;
   int errors = 0;

   direction_input #(
      .DEBOUNCE_CYCLES (4),
      .INITIAL_DELAY   (10),
      .REPEAT_PERIOD   (3),
      .CNT_W           (8)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .keys_n     (keys_n),
      .directions (directions),
      .held       (held)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Hold reset for two edges with the given keys, then release off-edge.
   task automatic restart(input logic [3:0] k);
      resetn = 1'b0;
      keys_n = k;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   function automatic logic [3:0] t5_dir(input int c);
      if (c == 7 || c == 17 || c == 20 || c == 23 || c == 26) return 4'b0001;
      if (c == 28 || c == 38 || c == 41 || c == 44) return 4'b0011;
      if (c == 47 || c == 50 || c == 53) return 4'b0010;
      return 4'b0000;
   endfunction

   function automatic logic [3:0] t5_held(input int c);
      if (c < 6) return 4'b0000;
      if (c < 27) return 4'b0001;
      if (c < 46) return 4'b0011;
      return 4'b0010;
   endfunction

   initial begin
      resetn = 1'b0;
      keys_n = 4'b1111;

      // 1: all four pressed through reset; both axes cancel.
      resetn = 1'b0;
      keys_n = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("t1 rst dir c%0d", c), directions, 4'b0000);
         chk($sformatf("t1 rst held c%0d", c), held, 4'b0000);
      end
      resetn = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         chk($sformatf("t1 held c%0d", c), held, (c >= 6) ? 4'b1111 : 4'b0000);
         chk($sformatf("t1 dir c%0d", c), directions, 4'b0000);
      end

      // 2: left held, then released at cycle 30.
      restart(4'b0111);
      for (int c = 1; c <= 50; c++) begin
         tick();
         chk($sformatf("t2 held c%0d", c), held, (c >= 6 && c < 36) ? 4'b1000 : 4'b0000);
         chk($sformatf("t2 dir c%0d", c), directions,
             (c == 7 || (c >= 17 && c <= 35 && (c - 17) % 3 == 0)) ? 4'b1000 : 4'b0000);
         if (c == 30) keys_n = 4'b1111;
      end

      // 3: 3-low/3-high glitches on left never pass the debouncer.
      restart(4'b1111);
      for (int c = 0; c < 40; c++) begin
         keys_n = ((c / 3) % 2 == 0) ? 4'b0111 : 4'b1111;
         tick();
         chk($sformatf("t3 held c%0d", c), held, 4'b0000);
         chk($sformatf("t3 dir c%0d", c), directions, 4'b0000);
      end
      keys_n = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         tick();
         chk($sformatf("t3 tail dir c%0d", c), directions, 4'b0000);
      end

      // 4: left+right cancel, then up added.
      restart(4'b0101);
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (c <= 20) begin
            chk($sformatf("t4 held c%0d", c), held, (c >= 6) ? 4'b1010 : 4'b0000);
            chk($sformatf("t4 dir c%0d", c), directions, 4'b0000);
         end else begin
            chk($sformatf("t4 held c%0d", c), held, (c >= 26) ? 4'b1110 : 4'b1010);
            chk($sformatf("t4 dir c%0d", c), directions,
                (c == 27 || (c >= 37 && (c - 37) % 3 == 0)) ? 4'b0100 : 4'b0000);
         end
         if (c == 20) keys_n = 4'b0001;
      end

      // 5: down into repeat, add right (delay restarts), then drop down.
      restart(4'b1110);
      for (int c = 1; c <= 55; c++) begin
         tick();
         chk($sformatf("t5 held c%0d", c), held, t5_held(c));
         chk($sformatf("t5 dir c%0d", c), directions, t5_dir(c));
         if (c == 21) keys_n = 4'b1100;
         if (c == 40) keys_n = 4'b1101;
      end

      // 6: reset hits during a repeat pulse; output must clear without a clock edge.
      restart(4'b1110);
      for (int c = 1; c <= 23; c++) begin
         tick();
         chk($sformatf("t6 dir c%0d", c), directions,
             (c == 7 || c == 17 || c == 20 || c == 23) ? 4'b0001 : 4'b0000);
      end
      resetn = 1'b0;
      #1;
      chk("t6 async dir", directions, 4'b0000);
      chk("t6 async held", held, 4'b0000);
      tick();
      tick();
      resetn = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk($sformatf("t6 held c%0d", c), held, (c >= 6) ? 4'b0001 : 4'b0000);
         chk($sformatf("t6 dir c%0d", c), directions,
             (c == 7 || c == 17 || c == 20) ? 4'b0001 : 4'b0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
